// File: rtl/dot_product_pkg.sv
// dot_product_pkg: state encoding and default sizing for the dot-product engine
package dot_product_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, DRAIN = 2'd2} state_e;
    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_VEC_LEN = 8;
endpackage

// File: rtl/dot_product_if.sv
// dot_product_if: start/result handshake plus the two FIFO read ports
interface dot_product_if import dot_product_pkg::*; #(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ACC_WIDTH = 2 * DEF_DATA_WIDTH + $clog2(DEF_VEC_LEN)
);
    logic start;
    logic a_empty;
    logic b_empty;
    logic [DATA_WIDTH-1:0] a_data;
    logic [DATA_WIDTH-1:0] b_data;
    logic a_rd_en;
    logic b_rd_en;
    logic [ACC_WIDTH-1:0] result;
    logic result_valid;
    logic busy;
    modport master (
        output start, a_empty, b_empty, a_data, b_data,
        input a_rd_en, b_rd_en, result, result_valid, busy
    );
    modport slave (
        input start, a_empty, b_empty, a_data, b_data,
        output a_rd_en, b_rd_en, result, result_valid, busy
    );
endinterface

// File: rtl/dot_product_mac_unit.sv
// mac_unit: unsigned multiply-accumulate register with clear and enable
module mac_unit #(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH = 19
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr_i,
    input  logic                  en_i,
    input  logic [DATA_WIDTH-1:0] a_i,
    input  logic [DATA_WIDTH-1:0] b_i,
    output logic [ACC_WIDTH-1:0]  sum_o
);
    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [2*DATA_WIDTH-1:0] prod;
    assign prod = {{DATA_WIDTH{1'b0}}, a_i} * {{DATA_WIDTH{1'b0}}, b_i};
    assign sum_o = acc_q + ACC_WIDTH'(prod);
    // clear wins over accumulate so a fresh vector always starts from zero
    always_comb begin
        acc_d = clr_i ? '0 : en_i ? sum_o : acc_q;
    end
    // accumulator register
    always_ff @(posedge clk) begin
        if (rst) acc_q <= '0;
        else acc_q <= acc_d;
    end
endmodule

// File: rtl/dot_product_fsm.sv
// dot_product_fsm: reads VEC_LEN operand pairs from two FIFOs and emits their dot product
module dot_product_fsm import dot_product_pkg::*; #(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int VEC_LEN = DEF_VEC_LEN,
    parameter int ACC_WIDTH = 2 * DATA_WIDTH + $clog2(VEC_LEN)
) (
    input logic clk,
    input logic rst,
    dot_product_if.slave bus
);
    localparam int CW = $clog2(VEC_LEN + 1);
    localparam logic [CW-1:0] LAST = CW'(VEC_LEN - 1);
    state_e state_q, state_d;
    logic [CW-1:0] issue_cnt_q, issue_cnt_d, mac_cnt_q, mac_cnt_d;
    logic pend_q;
    logic result_valid_q;
    logic [ACC_WIDTH-1:0] result_q, sum;
    logic accept, rd_en, last_mac;
    assign accept = state_q == IDLE && bus.start;
    assign rd_en = !rst && state_q == FETCH && !bus.a_empty && !bus.b_empty && issue_cnt_q < CW'(VEC_LEN);
    assign last_mac = pend_q && mac_cnt_q == LAST;
    assign bus.a_rd_en = rd_en;
    assign bus.b_rd_en = rd_en;
    assign bus.result = result_q;
    assign bus.result_valid = result_valid_q;
    assign bus.busy = state_q != IDLE;
    mac_unit #(.DATA_WIDTH(DATA_WIDTH), .ACC_WIDTH(ACC_WIDTH)) u_mac (
        .clk   (clk),
        .rst   (rst),
        .clr_i (accept),
        .en_i  (pend_q),
        .a_i   (bus.a_data),
        .b_i   (bus.b_data),
        .sum_o (sum)
    );
    // next state and counters; a read in flight (pend) always lands one cycle later
    always_comb begin
        state_d = accept ? FETCH
                : (state_q == FETCH && rd_en && issue_cnt_q == LAST) ? DRAIN
                : (state_q == DRAIN && last_mac) ? IDLE
                : state_q;
        issue_cnt_d = accept ? '0 : issue_cnt_q + CW'(rd_en);
        mac_cnt_d = accept ? '0 : mac_cnt_q + CW'(pend_q);
    end
    // state, counters and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            issue_cnt_q <= '0;
            mac_cnt_q <= '0;
            pend_q <= 1'b0;
            result_q <= '0;
            result_valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            issue_cnt_q <= issue_cnt_d;
            mac_cnt_q <= mac_cnt_d;
            pend_q <= rd_en;
            result_valid_q <= last_mac;
            if (last_mac) result_q <= sum;
        end
    end
endmodule
